// File: rtl/ocp_mem_slave_pkg.sv
// Shared bus widths and OCP command/response codes for the on-chip SRAM slave.
package ocp_mem_slave_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;
   localparam int BEN_WIDTH  = DATA_WIDTH / 8;

   localparam logic [2:0] OCP_CMD_IDLE  = 3'b000;
   localparam logic [2:0] OCP_CMD_WRITE = 3'b001;
   localparam logic [2:0] OCP_CMD_READ  = 3'b010;

   localparam logic [1:0] OCP_RESP_NULL = 2'b00;
   localparam logic [1:0] OCP_RESP_DVA  = 2'b01;
   localparam logic [1:0] OCP_RESP_ERR  = 2'b11;

endpackage

// File: rtl/ocp_mem_slave_array.sv
// Byte-lane SRAM with synchronous per-lane write and registered read, no reset.
// Isolated so a vendor memory macro can replace it without touching the control logic.
module ocp_mem_slave_array #(
   parameter int ADDR_BITS  = 12,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic                    re,
   input  logic [DATA_WIDTH/8-1:0] ben,
   input  logic [ADDR_BITS-1:0]    addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);

   logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_BITS)-1];

   always_ff @(posedge clk) begin
      for (int k = 0; k < DATA_WIDTH/8; k++) begin
         if (we && ben[k]) begin
            mem[addr][8*k +: 8] <= wdata[8*k +: 8];
         end
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/ocp_mem_slave.sv
// OCP SRAM slave: one command at a time, WAIT_STATES extra cycles, one response beat each.
// Define OCP_MEM_SLAVE_ERR_EN to answer out-of-range addresses and unknown commands with ERR.
module ocp_mem_slave
   import ocp_mem_slave_pkg::*;
#(
   parameter int MEM_WORDS_LOG2 = 12,
   parameter int WAIT_STATES    = 0
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic [ADDR_WIDTH-1:0] i_MAddr,
   input  logic [2:0]            i_MCmd,
   input  logic [DATA_WIDTH-1:0] i_MData,
   input  logic [BEN_WIDTH-1:0]  i_MByteEn,
   output logic                  o_SCmdAccept,
   output logic [DATA_WIDTH-1:0] o_SData,
   output logic [1:0]            o_SResp
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam int         IDX_HI   = MEM_WORDS_LOG2 + 1;
   localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   state_t                    state, next_state;
   logic [3:0]                cnt, next_cnt;
   logic                      take, enter_resp, rd_ok;
   logic                      live_write, live_err, addr_unused;
   logic [MEM_WORDS_LOG2-1:0] live_idx;
   logic                      wr_q, err_q;
   logic [MEM_WORDS_LOG2-1:0] idx_q;
   logic [DATA_WIDTH-1:0]     data_q, sdata_q, arr_rdata;
   logic [BEN_WIDTH-1:0]      ben_q;
   logic                      cur_write, cur_err;
   logic [MEM_WORDS_LOG2-1:0] cur_idx;
   logic [DATA_WIDTH-1:0]     cur_data;
   logic [BEN_WIDTH-1:0]      cur_ben;

   assign live_idx   = i_MAddr[IDX_HI:2];
   assign live_write = (i_MCmd == OCP_CMD_WRITE);

`ifdef OCP_MEM_SLAVE_ERR_EN
   assign live_err    = (|i_MAddr[ADDR_WIDTH-1:IDX_HI+1]) ||
                        !((i_MCmd == OCP_CMD_WRITE) || (i_MCmd == OCP_CMD_READ));
   assign addr_unused = ^i_MAddr[1:0];
`else
   // Upper address bits alias onto the array; any non-WRITE command reads.
   assign live_err    = 1'b0;
   assign addr_unused = ^{i_MAddr[ADDR_WIDTH-1:IDX_HI+1], i_MAddr[1:0]};
`endif

   assign o_SCmdAccept = (state == S_IDLE);
   assign take         = o_SCmdAccept && (i_MCmd != OCP_CMD_IDLE);
   assign rd_ok        = !wr_q && !err_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      case (state)
         S_IDLE: begin
            if (take) begin
               if (WAIT_STATES > 0) begin
                  next_state = S_WAIT;
                  next_cnt   = CNT_INIT;
               end else begin
                  next_state = S_RESP;
               end
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) begin
               next_state = S_RESP;
            end else begin
               next_cnt = cnt - 4'd1;
            end
         end
         S_RESP:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // With zero wait states the array is accessed on the accept edge, before the latches hold the command.
   assign enter_resp = (next_state == S_RESP) && (state != S_RESP);
   assign cur_write  = (state == S_IDLE) ? live_write : wr_q;
   assign cur_err    = (state == S_IDLE) ? live_err   : err_q;
   assign cur_idx    = (state == S_IDLE) ? live_idx   : idx_q;
   assign cur_data   = (state == S_IDLE) ? i_MData    : data_q;
   assign cur_ben    = (state == S_IDLE) ? i_MByteEn  : ben_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         data_q  <= '0;
         ben_q   <= '0;
         sdata_q <= '0;
      end else begin
         if (take) begin
            wr_q   <= live_write;
            err_q  <= live_err;
            idx_q  <= live_idx;
            data_q <= i_MData;
            ben_q  <= i_MByteEn;
         end
         if ((state == S_RESP) && rd_ok) begin
            sdata_q <= arr_rdata;
         end
      end
   end

   ocp_mem_slave_array #(
      .ADDR_BITS  (MEM_WORDS_LOG2),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_array (
      .clk   (clk),
      .we    (enter_resp && cur_write && !cur_err),
      .re    (enter_resp && !cur_write && !cur_err),
      .ben   (cur_ben),
      .addr  (cur_idx),
      .wdata (cur_data),
      .rdata (arr_rdata)
   );

   // Read data comes straight from the array register during the response beat, then is held.
   assign o_SData = ((state == S_RESP) && rd_ok) ? arr_rdata : sdata_q;
   assign o_SResp = (state != S_RESP) ? OCP_RESP_NULL :
                    (err_q ? OCP_RESP_ERR : OCP_RESP_DVA);

endmodule

// File: tb/tb_ocp_mem_slave.sv
// Scoreboard bench for ocp_mem_slave: one instance with no wait states, one with three.
// Expected responses are queued at accept and popped when a response beat appears.
module tb_ocp_mem_slave;

   localparam logic [2:0] CMD_IDLE = 3'b000;
   localparam logic [2:0] CMD_WR   = 3'b001;
   localparam logic [2:0] CMD_RD   = 3'b010;
   localparam logic [1:0] RSP_NULL = 2'b00;
   localparam logic [1:0] RSP_DVA  = 2'b01;
   localparam logic [1:0] RSP_ERR  = 2'b11;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] data;
      int          cyc;
      string       tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic [31:0] m_addr = '0;
   logic [2:0]  m_cmd = CMD_IDLE;
   logic [31:0] m_data = '0;
   logic [3:0]  m_ben = '0;
   int          sel = 0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   logic [2:0]  cmd0, cmd3;
   logic        acc0, acc3, acc;
   logic [31:0] sdata0, sdata3, sdata;
   logic [1:0]  sresp0, sresp3, sresp;

   exp_t        sbq[$];
   logic [31:0] mdl [0:1][0:4095];
   logic [31:0] last_data [0:1];

   assign cmd0  = (sel == 0) ? m_cmd : CMD_IDLE;
   assign cmd3  = (sel == 1) ? m_cmd : CMD_IDLE;
   assign acc   = (sel == 0) ? acc0 : acc3;
   assign sdata = (sel == 0) ? sdata0 : sdata3;
   assign sresp = (sel == 0) ? sresp0 : sresp3;

   ocp_mem_slave #(.MEM_WORDS_LOG2(12), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .nrst(nrst), .i_MAddr(m_addr), .i_MCmd(cmd0), .i_MData(m_data),
      .i_MByteEn(m_ben), .o_SCmdAccept(acc0), .o_SData(sdata0), .o_SResp(sresp0)
   );

   ocp_mem_slave #(.MEM_WORDS_LOG2(12), .WAIT_STATES(3)) u_dut3 (
      .clk(clk), .nrst(nrst), .i_MAddr(m_addr), .i_MCmd(cmd3), .i_MData(m_data),
      .i_MByteEn(m_ben), .o_SCmdAccept(acc3), .o_SData(sdata3), .o_SResp(sresp3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour: word index from address bits [13:2], lane merge, ERR rules when enabled.
   task automatic pushExpect(input logic [2:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] ben, input string tag, input int t);
      exp_t        e;
      int          idx;
      logic        err;
      logic [31:0] w;
      idx = int'(addr[13:2]);
      err = 1'b0;
`ifdef OCP_MEM_SLAVE_ERR_EN
      err = (addr[31:14] != 18'd0) || ((cmd != CMD_WR) && (cmd != CMD_RD));
`endif
      e.tag = tag;
      e.cyc = t + 1 + ((sel == 1) ? 3 : 0);
      if (err) begin
         e.resp = RSP_ERR;
         e.data = last_data[sel];
      end else if (cmd == CMD_WR) begin
         w = mdl[sel][idx];
         for (int k = 0; k < 4; k++) begin
            if (ben[k]) w[8*k +: 8] = data[8*k +: 8];
         end
         mdl[sel][idx] = w;
         e.resp = RSP_DVA;
         e.data = last_data[sel];
      end else begin
         e.resp = RSP_DVA;
         e.data = mdl[sel][idx];
         last_data[sel] = e.data;
      end
      sbq.push_back(e);
   endtask

   task automatic waitDrain(input string tag);
      int n;
      n = 0;
      while ((sbq.size() != 0) && (n < 100)) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checkOutput({tag, "_drain"}, 64'(sbq.size()), 64'd0);
   endtask

   task automatic applyStimulus(input logic [2:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] ben, input string tag);
      int n;
      @(negedge clk);
      m_cmd = cmd; m_addr = addr; m_data = data; m_ben = ben;
      n = 0;
      while (!acc && (n < 100)) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_accept"}, 64'(acc), 64'd1);
      if (acc) pushExpect(cmd, addr, data, ben, tag, cyc);
      @(posedge clk);
      #1 m_cmd = CMD_IDLE;
      waitDrain(tag);
   endtask

   // Every response beat must match the oldest outstanding expectation, including its cycle.
   always @(negedge clk) begin
      exp_t e;
      if (nrst && (sresp != RSP_NULL)) begin
         if (sbq.size() == 0) begin
            checkOutput("unexpected_resp", 64'(sresp), 64'(RSP_NULL));
         end else begin
            e = sbq.pop_front();
            checkOutput({e.tag, "_resp"}, 64'(sresp), 64'(e.resp));
            checkOutput({e.tag, "_data"}, 64'(sdata), 64'(e.data));
            checkOutput({e.tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
         end
      end
   end

   initial begin
      int t0;
      logic [31:0] a, d;
      last_data[0] = '0;
      last_data[1] = '0;

      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s;
         #1;
         checkOutput("rst_resp", 64'(sresp), 64'(RSP_NULL));
         checkOutput("rst_data", 64'(sdata), 64'd0);
         checkOutput("rst_accept", 64'(acc), 64'd1);
      end
      sel = 0;
      @(negedge clk) nrst = 1'b1;

      // Zero wait states: full, partial and empty byte-enable writes
      applyStimulus(CMD_WR, 32'h10, 32'hDEADBEEF, 4'hF, "w_full");
      applyStimulus(CMD_RD, 32'h10, 32'h0, 4'h0, "r_full");
      applyStimulus(CMD_WR, 32'h10, 32'h12345678, 4'h3, "w_part");
      applyStimulus(CMD_RD, 32'h10, 32'h0, 4'hF, "r_part");
      applyStimulus(CMD_WR, 32'h10, 32'hFFFFFFFF, 4'h0, "w_noben");
      applyStimulus(CMD_RD, 32'h10, 32'h0, 4'h0, "r_noben");

      // Aliasing / ERR handling on word 0 (the model decides which applies)
      applyStimulus(CMD_WR, 32'h0, 32'h13579BDF, 4'hF, "w_word0");
      applyStimulus(CMD_WR, 32'h4003, 32'h55AA55AA, 4'hF, "w_alias");
      applyStimulus(CMD_RD, 32'h0, 32'h0, 4'h0, "r_alias");
      applyStimulus(CMD_WR, 32'h00010000, 32'hFFFFFFFF, 4'hF, "w_high");
      applyStimulus(CMD_RD, 32'h0, 32'h0, 4'h0, "r_after_high");
      applyStimulus(3'b011, 32'h0, 32'h0, 4'h0, "cmd_011");

      // Random byte-lane traffic over pre-initialised words
      for (int i = 0; i < 8; i++) begin
         applyStimulus(CMD_WR, 32'h100 + 32'(4 * i), $urandom, 4'hF, "w_init");
      end
      for (int i = 0; i < 12; i++) begin
         a = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
         d = $urandom;
         applyStimulus(CMD_WR, a, d, 4'($urandom_range(0, 15)), "w_rand");
         applyStimulus(CMD_RD, a, 32'h0, 4'($urandom_range(0, 15)), "r_rand");
      end

      // Three wait states: latency and back-to-back acceptance with the command held
      sel = 1;
      applyStimulus(CMD_WR, 32'h20, 32'hA5A50F0F, 4'hF, "ws_w");
      applyStimulus(CMD_RD, 32'h20, 32'h0, 4'h0, "ws_r");
      @(negedge clk);
      m_cmd = CMD_RD; m_addr = 32'h20; m_ben = 4'h0;
      checkOutput("b2b_first_accept", 64'(acc), 64'd1);
      t0 = cyc;
      pushExpect(CMD_RD, 32'h20, 32'h0, 4'h0, "b2b_first", t0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         checkOutput("b2b_busy", 64'(acc), 64'd0);
      end
      @(negedge clk);
      checkOutput("b2b_second_accept", 64'(acc), 64'd1);
      checkOutput("b2b_accept_cycle", 64'(cyc), 64'(t0 + 5));
      pushExpect(CMD_RD, 32'h20, 32'h0, 4'h0, "b2b_second", cyc);
      @(posedge clk);
      #1 m_cmd = CMD_IDLE;
      waitDrain("b2b");

      // Reset in the second wait cycle drops a pending write
      applyStimulus(CMD_WR, 32'h40, 32'h11112222, 4'hF, "pre_rst_w");
      @(negedge clk);
      m_cmd = CMD_WR; m_addr = 32'h40; m_data = 32'hCAFEF00D; m_ben = 4'hF;
      checkOutput("midrst_accept", 64'(acc), 64'd1);
      @(posedge clk);
      #1 m_cmd = CMD_IDLE;
      @(negedge clk);
      @(negedge clk);
      nrst = 1'b0;
      #1;
      checkOutput("midrst_resp", 64'(sresp), 64'(RSP_NULL));
      checkOutput("midrst_accept_after", 64'(acc), 64'd1);
      checkOutput("midrst_data", 64'(sdata), 64'd0);
      last_data[0] = '0;
      last_data[1] = '0;
      @(negedge clk) nrst = 1'b1;
      applyStimulus(CMD_RD, 32'h40, 32'h0, 4'h0, "post_rst_r");
      applyStimulus(CMD_WR, 32'h44, 32'h0BADF00D, 4'hC, "ws_w_part_init");
      applyStimulus(CMD_RD, 32'h44, 32'h0, 4'h0, "ws_r_part");

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ocp_mem_slave.md
Name: ocp_mem_slave

Overview:
- On-chip SRAM slave that sits on one fabric slave port (e.g. P0) and consumes the OCP request stream that port produces.
- Accepts one OCP read or write at a time and inserts a configurable number of wait states.
- Returns exactly one response beat per accepted command. Writes also return DVA, so the fabric's per-port transaction tracking can retire them.
- Addresses arriving here are already rebased by the fabric decoder.

Parameters:
- MEM_WORDS_LOG2, 12, log2 of memory depth in DATA_WIDTH-bit words (default 4096 words = 16 KiB).
- WAIT_STATES, 0, extra cycles between command accept and response (0..15).

Ports:
- clk  input  1  system clock.
- nrst  input  1  asynchronous active-low reset.
- i_MAddr  input  `ADDR_WIDTH  byte address, rebased by fabric.
- i_MCmd  input  3  OCP command (`OCP_CMD_IDLE/WRITE/READ).
- i_MData  input  `DATA_WIDTH  write data.
- i_MByteEn  input  `BEN_WIDTH  write byte lane enables.
- o_SCmdAccept  output  1  command accepted this cycle.
- o_SData  output  `DATA_WIDTH  read data, valid while o_SResp=DVA.
- o_SResp  output  2  OCP response (`OCP_RESP_NULL/DVA/ERR).

Behaviour:
- Reset: one clock, clk; reset nrst is asynchronous and active-low. During and after reset: state=S_IDLE, o_SResp=NULL, o_SData=0, wait counter=0. o_SCmdAccept=1 because accept is combinational on S_IDLE. Memory contents are not reset.
- o_SCmdAccept = (state==S_IDLE). It is 0 in S_WAIT and S_RESP.
- Accept: in S_IDLE with i_MCmd!=IDLE, the command is accepted in that same cycle T. Latch cmd, word index = i_MAddr[MEM_WORDS_LOG2+1:2], data and byte enables.
- Accept transitions:
  - If WAIT_STATES>0: go to S_WAIT, counter=WAIT_STATES-1.
  - Otherwise: go to S_RESP.
- S_WAIT: decrement the counter each cycle. When the counter is 0, go to S_RESP.
- Write commit: the array write occurs on the clock edge that enters S_RESP. Only byte lanes with MByteEn[k]=1 are written. MByteEn=0 is a no-op that still returns DVA.
- Read: the full word is read on the same edge and registered into o_SData. Byte enables are ignored.
- S_RESP: o_SResp=DVA for exactly one cycle (T+1+WAIT_STATES), then return to S_IDLE. Earliest next accept is T+2+WAIT_STATES.
- o_SData: updated only by reads. It holds its value on writes and on idle cycles.
- Address handling: low address bits [1:0] are ignored (word aligned).
- Read-after-write to the same word returns the new data.
- Reset mid-operation: an async reset in S_WAIT drops the pending command; no write occurs and no response is issued. Reset in S_RESP clears o_SResp immediately.
- Master contract: i_MCmd may change freely after accept. The slave never samples it outside S_IDLE.

Optional Feature:
- Macro: OCP_MEM_SLAVE_ERR_EN.
- Defined: at accept, an access produces o_SResp=ERR (same latency as DVA, no array write, o_SData unchanged) when either:
  - any i_MAddr bit in [`ADDR_WIDTH-1:MEM_WORDS_LOG2+2] is nonzero, or
  - i_MCmd is neither WRITE nor READ.
- Undefined: upper address bits are ignored (the memory aliases), and any non-IDLE command other than WRITE is treated as READ. The slave never returns ERR.

Decomposition:
- Shared headers: `ADDR_WIDTH/`DATA_WIDTH/`BEN_WIDTH stay in common.vh; OCP command and response codes stay in ocp_const.vh. No new shared constants.
- State encodings S_IDLE/S_WAIT/S_RESP are local to the block.
- One natural sub-module, ocp_mem_slave_array: byte-lane RAM, DEPTH=2^MEM_WORDS_LOG2, synchronous per-lane write, synchronous read, no reset. Kept separate so it can be swapped for a vendor macro.

Test Plan:
- WAIT_STATES=0: WRITE 0xDEADBEEF @0x10, BEN=0xF → accept cycle T, DVA at T+1. Then READ @0x10 → DVA with SData=0xDEADBEEF.
- Partial write: over 0xDEADBEEF @0x10, WRITE 0x12345678 with BEN=0x3 → DVA. READ @0x10 returns 0xDEAD5678. A write with BEN=0x0 leaves the word unchanged and still returns DVA.
- WAIT_STATES=2: READ @0x20 accepted at T → SCmdAccept=0 at T+1..T+3, DVA only at T+3. A back-to-back command held on i_MCmd is accepted at T+4.
- Reset mid-operation (WAIT_STATES=3): WRITE 0xCAFEF00D @0x40, assert nrst low in the 2nd wait cycle → SResp=NULL immediately and SCmdAccept=1 after reset. A subsequent READ @0x40 returns the prior contents.
- Alignment/aliasing, macro undefined, MEM_WORDS_LOG2=12: WRITE 0x55AA55AA @0x4003 → READ @0x0000 returns 0x55AA55AA with DVA.
- OCP_MEM_SLAVE_ERR_EN defined, MEM_WORDS_LOG2=12: WRITE @0x00010000 → SResp=ERR, and word 0 is unmodified. MCmd=3'b011 @0x0 → ERR.
